// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//   Parallel-to-serial frame transmitter. One WIDTH-bit word is accepted per
//   valid/ready handshake and sent on a single registered line as a start bit
//   '1', WIDTH data bits, then a return to '0'. After the frame the line stays
//   low for GAP extra cycles before a new word can be accepted. The idle level
//   '0' matches the reset value of the serial flip-flop pipeline this drives.
//
// Ports
//   clk          in   1      clock, all state on rising edge
//   async_reset  in   1      asynchronous, active-high reset
//   in_data      in   WIDTH  word to send, sampled only on the accept edge
//   in_valid     in   1      source has a word
//   in_ready     out  1      block can accept (state is IDLE)
//   tx_serial    out  1      registered serial line
//   busy         out  1      frame or gap in progress (state is not IDLE)
//   frame_done   out  1      one-cycle pulse in the cycle tx_serial returns to 0
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_serial,
    output logic             busy,
    output logic             frame_done
);

    localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
    // With GAP == 0 the GAP state is unreachable, so this value is never used.
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
    logic [GCNT_W-1:0] gcnt_q,  gcnt_d;
    logic              tx_q,    tx_d;
    logic              done_q,  done_d;

    logic              next_bit;
    logic [WIDTH-1:0]  shreg_shifted;

    // Bit order is fixed at elaboration: take the outgoing end of the shift
    // register and move the remaining bits toward it.
    assign next_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b0;
                if (in_valid) begin
                    shreg_d = in_data;
                    tx_d    = 1'b1;
                    bcnt_d  = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                tx_d    = next_bit;
                shreg_d = shreg_shifted;
                // Hold on the last bit instead of incrementing so the counter
                // never wraps, even when WIDTH is a power of two.
                if (bcnt_q == BCNT_LAST) begin
                    state_d = S_STOP;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end

            S_STOP: begin
                tx_d   = 1'b0;
                done_d = 1'b1;
                if (GAP > 0) begin
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GAP: begin
                tx_d = 1'b0;
                if (gcnt_q == GCNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset is asynchronous so an aborted frame drops the line at once,
    // not on the next clock edge.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign tx_serial  = tx_q;
    assign frame_done = done_q;

endmodule
